// File: rtl/xy_avg_pkg.sv
// xy_avg_pkg: state encoding and accumulator sizing shared by the averaging block and the iteration controller.
package xy_avg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        DIV  = ST_DIV,
        DONE = ST_DONE
    } state_e;

    // Wide enough that a full batch of extreme samples never overflows.
    function automatic int sum_w(input int data_w, input int n_log2);
        return data_w + n_log2;
    endfunction

endpackage

// File: rtl/xy_avg_accum_if.sv
// xy_avg_accum_if: sample/average handshake and read-back port between the iteration controller (master) and xy_avg_accum (slave).
interface xy_avg_accum_if #(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 4
);

    logic                     clear_in;
    logic                     xy_valid_in;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     avg_valid_out;
    logic signed [DATA_W-1:0] x_avg;
    logic signed [DATA_W-1:0] y_avg;
    logic                     busy;
    logic                     drop_flag;
    logic                     rd_en;
    logic [N_LOG2-1:0]        rd_idx;
    logic signed [DATA_W-1:0] rd_x;
    logic signed [DATA_W-1:0] rd_y;
    logic                     rd_valid;

    modport master (
        output clear_in, xy_valid_in, x_in, y_in, rd_en, rd_idx,
        input  avg_valid_out, x_avg, y_avg, busy, drop_flag, rd_x, rd_y, rd_valid
    );

    modport slave (
        input  clear_in, xy_valid_in, x_in, y_in, rd_en, rd_idx,
        output avg_valid_out, x_avg, y_avg, busy, drop_flag, rd_x, rd_y, rd_valid
    );

endinterface

// File: rtl/xy_sample_buf.sv
// xy_sample_buf: 2^A-entry sample store, one write port and one registered read port (read-before-write).
module xy_sample_buf #(
    parameter int W = 32,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [A-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         re_i,
    input  logic [A-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [1<<A];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/xy_avg_accum.sv
// xy_avg_accum: collects a batch of 2^N_LOG2 signed (x, y) samples, presents their means and serves indexed read-back.
// Define AVG_ROUND_EN to round the means half toward +inf (saturated) instead of flooring.
module xy_avg_accum
    import xy_avg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 4
) (
    input logic           clk,
    input logic           rst_n,
    xy_avg_accum_if.slave bus
);

    localparam int SUM_W = sum_w(DATA_W, N_LOG2);
    localparam int N     = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

`ifdef AVG_ROUND_EN
    localparam int SW1 = SUM_W + 1;
    localparam logic signed [SW1-1:0] AVG_MAX = {{(SW1-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW1-1:0] AVG_MIN = {{(SW1-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [SW1-1:0] HALF    = SW1'(1 << (N_LOG2 - 1));
`endif

    state_e                   state_q;
    logic [N_LOG2-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic signed [DATA_W-1:0] x_avg_q, y_avg_q;
    logic                     avg_valid_q, drop_q, rd_valid_q;
    logic                     wr_en;
    logic [2*DATA_W-1:0]      rd_data;

    function automatic logic signed [DATA_W-1:0] avg_of(input logic signed [SUM_W-1:0] s);
`ifdef AVG_ROUND_EN
        logic signed [SW1-1:0] w;
        w = (SW1'(s) + HALF) >>> N_LOG2;
        return (w > AVG_MAX) ? DATA_W'(AVG_MAX) : (w < AVG_MIN) ? DATA_W'(AVG_MIN) : DATA_W'(w);
`else
        return DATA_W'(s >>> N_LOG2);
`endif
    endfunction

    // Clear wins over a coincident strobe, so the buffer must not see that sample either.
    assign wr_en = bus.xy_valid_in && !bus.clear_in && (state_q == IDLE || state_q == ACC);

    always_comb begin
        sum_x_d = (state_q == IDLE ? '0 : sum_x_q) + SUM_W'(bus.x_in);
        sum_y_d = (state_q == IDLE ? '0 : sum_y_q) + SUM_W'(bus.y_in);
        cnt_d   = cnt_q + N_LOG2'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            x_avg_q     <= '0;
            y_avg_q     <= '0;
            avg_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en & avg_valid_q;
            if (bus.clear_in) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                sum_x_q     <= '0;
                sum_y_q     <= '0;
                x_avg_q     <= '0;
                y_avg_q     <= '0;
                avg_valid_q <= 1'b0;
                drop_q      <= 1'b0;
            end else begin
                if (bus.xy_valid_in && (state_q == DIV || state_q == DONE)) drop_q <= 1'b1;
                case (state_q)
                    // cnt_q is 0 in IDLE and LAST >= 1, so IDLE always moves to ACC.
                    IDLE, ACC: if (wr_en) begin
                        sum_x_q <= sum_x_d;
                        sum_y_q <= sum_y_d;
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_q == LAST) ? DIV : ACC;
                    end
                    DIV: begin
                        x_avg_q     <= avg_of(sum_x_q);
                        y_avg_q     <= avg_of(sum_y_q);
                        avg_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    xy_sample_buf #(
        .W (2 * DATA_W),
        .A (N_LOG2)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (cnt_q),
        .wdata_i ({bus.x_in, bus.y_in}),
        .re_i    (bus.rd_en),
        .raddr_i (bus.rd_idx),
        .rdata_o (rd_data)
    );

    assign bus.avg_valid_out = avg_valid_q;
    assign bus.x_avg         = x_avg_q;
    assign bus.y_avg         = y_avg_q;
    assign bus.busy          = (state_q == ACC) || (state_q == DIV);
    assign bus.drop_flag     = drop_q;
    assign bus.rd_x          = rd_data[2*DATA_W-1:DATA_W];
    assign bus.rd_y          = rd_data[DATA_W-1:0];
    assign bus.rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_xy_avg_accum.sv
// tb_xy_avg_accum: scoreboard bench for xy_avg_accum with N_LOG2=2, DATA_W=16.
module tb_xy_avg_accum;

    localparam int DW = 16;
    localparam int NL = 2;
    localparam int N  = 1 << NL;

    typedef struct {
        int x;
        int y;
    } pair_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    errors = 0;
    int    checks = 0;
    pair_t avg_q[$];
    pair_t rd_q[$];
    int    smp_x [N];
    int    smp_y [N];
    int    last_x, last_y;
    logic  avg_prev = 1'b0;

    xy_avg_accum_if #(.DATA_W(DW), .N_LOG2(NL)) bus ();

    xy_avg_accum #(.DATA_W(DW), .N_LOG2(NL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_avg(input int sum);
`ifdef AVG_ROUND_EN
        int r;
        r = (sum + (1 << (NL - 1))) >>> NL;
        return (r > 32767) ? 32767 : (r < -32768) ? -32768 : r;
`else
        return sum >>> NL;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int x, input int y);
        bus.xy_valid_in = 1'b1;
        bus.x_in = DW'(x);
        bus.y_in = DW'(y);
        tick();
        bus.xy_valid_in = 1'b0;
    endtask

    task automatic send_batch(input int xs [N], input int ys [N], input int gap, input bit probe);
        int sx = 0;
        int sy = 0;
        for (int i = 0; i < N; i++) begin
            sx += xs[i];
            sy += ys[i];
            smp_x[i] = xs[i];
            smp_y[i] = ys[i];
            if (i == N - 1) begin
                last_x = model_avg(sx);
                last_y = model_avg(sy);
                avg_q.push_back('{last_x, last_y});
            end
            send_one(xs[i], ys[i]);
            if (i < N - 1) repeat (gap) tick();
            if (probe && i == 1) begin
                bus.rd_en = 1'b1;
                bus.rd_idx = '0;
                tick();
                bus.rd_en = 1'b0;
                check("rd_valid_in_acc", bus.rd_valid, 0);
            end
        end
    endtask

    task automatic check_latency;
        check("div_busy", bus.busy, 1);
        check("div_avg_valid", bus.avg_valid_out, 0);
        tick();
        check("done_avg_valid", bus.avg_valid_out, 1);
        check("done_busy", bus.busy, 0);
    endtask

    // Scoreboard: averages popped on the rising edge of avg_valid_out, reads on rd_valid.
    always @(negedge clk) begin
        if (bus.avg_valid_out && !avg_prev) begin
            if (avg_q.size() == 0) check("avg_unexpected", 1, 0);
            else begin
                check("x_avg", bus.x_avg, avg_q[0].x);
                check("y_avg", bus.y_avg, avg_q[0].y);
                void'(avg_q.pop_front());
            end
        end
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                check("rd_x", bus.rd_x, rd_q[0].x);
                check("rd_y", bus.rd_y, rd_q[0].y);
                void'(rd_q.pop_front());
            end
        end
        avg_prev <= bus.avg_valid_out;
    end

    initial begin
        rst_n = 1'b1;
        bus.clear_in = 1'b0;
        bus.xy_valid_in = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.rd_en = 1'b0;
        bus.rd_idx = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_avg_valid", bus.avg_valid_out, 0);
        check("rst_x_avg", bus.x_avg, 0);
        check("rst_y_avg", bus.y_avg, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop_flag, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        send_batch('{1, 2, 3, 4}, '{10, 20, 30, 40}, 0, 1'b0);
        check_latency();
        for (int i = 0; i < N; i++) begin
            bus.rd_en = 1'b1;
            bus.rd_idx = NL'(i);
            rd_q.push_back('{smp_x[i], smp_y[i]});
            tick();
        end
        bus.rd_en = 1'b0;
        tick();

        send_one(99, 99);
        check("drop_set", bus.drop_flag, 1);
        check("drop_avg_valid", bus.avg_valid_out, 1);
        check("drop_x_stable", bus.x_avg, last_x);
        check("drop_y_stable", bus.y_avg, last_y);
        tick();

        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
        check("clr_avg_valid", bus.avg_valid_out, 0);
        check("clr_drop", bus.drop_flag, 0);
        check("clr_x_avg", bus.x_avg, 0);
        check("clr_busy", bus.busy, 0);

        send_batch('{-1, -2, -3, -4}, '{5, -7, 100, -100}, 3, 1'b1);
        check_latency();
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;

        send_one(50, 50);
        send_one(60, 60);
        check("acc_busy", bus.busy, 1);
        bus.clear_in = 1'b1;
        bus.xy_valid_in = 1'b1;
        bus.x_in = DW'(77);
        bus.y_in = DW'(77);
        tick();
        bus.clear_in = 1'b0;
        bus.xy_valid_in = 1'b0;
        check("clrv_busy", bus.busy, 0);
        check("clrv_drop", bus.drop_flag, 0);
        check("clrv_avg_valid", bus.avg_valid_out, 0);

        send_batch('{8, 8, 8, 9}, '{-4, -4, -4, -5}, 0, 1'b0);
        check_latency();

        send_one(1, 1);
        bus.rd_en = 1'b1;
        bus.rd_idx = NL'(3);
        rd_q.push_back('{9, -5});
        tick();
        bus.rd_en = 1'b0;
        #6 rst_n = 1'b0;
        #1;
        check("arst_done_avg_valid", bus.avg_valid_out, 0);
        check("arst_done_x_avg", bus.x_avg, 0);
        check("arst_done_y_avg", bus.y_avg, 0);
        check("arst_done_drop", bus.drop_flag, 0);
        check("arst_done_rd_valid", bus.rd_valid, 0);
        check("arst_done_rd_x", bus.rd_x, 0);
        tick();
        rst_n = 1'b1;
        tick();

        send_one(5, 5);
        send_one(6, 6);
        check("pre_arst_busy", bus.busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_acc_busy", bus.busy, 0);
        check("arst_acc_avg_valid", bus.avg_valid_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        send_batch('{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 1, 1'b0);
        check_latency();
        repeat (2) tick();

        check("avg_q_drained", avg_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
